// File: rtl/odo_pkg.sv
// Shared constants for the odometer trip counter: gear select encodings,
// gear FSM state encodings and the BCD digit limit.
package odo_pkg;

  localparam logic [1:0] GEAR_D = 2'b10;  // forward
  localparam logic [1:0] GEAR_R = 2'b01;  // reverse
  localparam logic [1:0] GEAR_P = 2'b00;  // park (2'b11 also parks)

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2
  } gear_e;

endpackage

// File: rtl/odo_bcd_counter_if.sv
// Signal bundle between the odometer core and its environment.
// master = stimulus/host side, slave = odometer core.
interface odo_bcd_counter_if;
  logic       wheel_pulse;
  logic [1:0] drive;
  logic       frame_tick;
  logic       clear;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic       ovf;

  modport master (output wheel_pulse, drive, frame_tick, clear,
                  input  a, b, c, ovf);
  modport slave  (input  wheel_pulse, drive, frame_tick, clear,
                  output a, b, c, ovf);
endinterface

// File: rtl/bcd_digit.sv
// One mod-10 up/down BCD digit. Steps when en_i and cin_i are both high;
// cout_o ripples combinationally so a whole chain settles in one cycle.
module bcd_digit
  import odo_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       cin_i,
  output logic [3:0] q_o,
  output logic       cout_o
);

  logic [3:0] q_q, q_d;

  // next digit value: clear wins, otherwise wrap 9->0 up and 0->9 down
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (en_i && cin_i) begin
      if (up_i) q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      else      q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  // digit register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) q_q <= 4'd0;
    else          q_q <= q_d;
  end

  // carry (up) or borrow (down) out; independent of en_i so the chain
  // tail can be used as the "at limit" indicator without a loop
  assign cout_o = cin_i & (up_i ? (q_q == BCD_MAX) : (q_q == 4'd0));
  assign q_o    = q_q;

endmodule

// File: rtl/odo_bcd_counter.sv
// Odometer trip counter: synchronised wheel pulse edges step a 3-digit
// BCD count up in D, down in R, ignored in P. Display digits are copied
// only on frame_tick so the readout never tears mid-frame.
// Build option: ODO_SATURATE_EN -- hold at 999 on forward overflow
// instead of wrapping to 000.
module odo_bcd_counter
  import odo_pkg::*;
(
  input  logic              clk_25MHz,
  input  logic              rst_n,
  odo_bcd_counter_if.slave  odo
);

  // [0] sync stage 1, [1] sync stage 2, [2] edge history
  logic [2:0] pulse_pipe_q;
  logic       tick;

  gear_e state_q, state_d;

  logic [NUM_DIGITS-1:0][3:0] dig;
  logic [NUM_DIGITS:0]        chain;
  logic [NUM_DIGITS-1:0][3:0] disp_q;
  logic                       ovf_q, ovf_d;
  logic                       fwd_tick, rev_tick, limit, block, step_en;

  // wheel pulse synchroniser plus history flop
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) pulse_pipe_q <= '0;
    else        pulse_pipe_q <= {pulse_pipe_q[1:0], odo.wheel_pulse};
  end

  assign tick = pulse_pipe_q[1] & ~pulse_pipe_q[2];

  // gear state register
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) state_q <= ST_PARK;
    else        state_q <= state_d;
  end

  // gear next state: a direct D<->R request falls to PARK first, and PARK
  // then picks up the new gear on the following cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PARK: begin
        if      (odo.drive == GEAR_D) state_d = ST_FWD;
        else if (odo.drive == GEAR_R) state_d = ST_REV;
      end
      ST_FWD:  if (odo.drive != GEAR_D) state_d = ST_PARK;
      ST_REV:  if (odo.drive != GEAR_R) state_d = ST_PARK;
      default: state_d = ST_PARK;
    endcase
  end

  assign fwd_tick = tick & (state_q == ST_FWD);
  assign rev_tick = tick & (state_q == ST_REV);

  // chain tail high means every digit sits at 9 (up) or 0 (down)
  assign chain[0] = 1'b1;
  assign limit    = (fwd_tick | rev_tick) & chain[NUM_DIGITS];

`ifdef ODO_SATURATE_EN
  assign block = limit;
`else
  assign block = rev_tick & chain[NUM_DIGITS];
`endif

  assign step_en = (fwd_tick | rev_tick) & ~block;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .clk_i   (clk_25MHz),
        .rst_n_i (rst_n),
        .clr_i   (odo.clear),
        .en_i    (step_en),
        .up_i    (state_q == ST_FWD),
        .cin_i   (chain[g]),
        .q_o     (dig[g]),
        .cout_o  (chain[g+1])
      );
    end
  endgenerate

  // sticky limit flag; trip clear drops it
  always_comb begin
    ovf_d = ovf_q;
    if (odo.clear)  ovf_d = 1'b0;
    else if (limit) ovf_d = 1'b1;
  end

  // flag and display registers; display takes the pre-update count
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      disp_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (odo.frame_tick) disp_q <= dig;
    end
  end

  assign odo.a   = disp_q[2];
  assign odo.b   = disp_q[1];
  assign odo.c   = disp_q[0];
  assign odo.ovf = ovf_q;

endmodule

// File: tb/tb_odo_bcd_counter.sv
// Self-checking bench for odo_bcd_counter: table-driven scenarios,
// hand-timed corner sequences and a randomized phase, all compared
// each cycle against a decimal-arithmetic reference model.
module tb_odo_bcd_counter;
  import odo_pkg::*;

`ifdef ODO_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk_25MHz = 1'b0;
  logic rst_n     = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  odo_bcd_counter_if ifc ();

  odo_bcd_counter dut (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .odo       (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model: plain decimal count, gear as 0=P 1=F 2=R,
  // and the last three sampled wheel levels (h0 newest)
  int m_cnt, m_disp, m_gear;
  bit m_ovf, h0, h1, h2;

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    bit tk;
    int want;
    if (!rst_n) begin
      m_cnt = 0; m_disp = 0; m_ovf = 0; m_gear = 0;
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      // a rising wheel level is seen two edges after it is first sampled
      tk = h1 && !h2;
      if (ifc.frame_tick) m_disp = m_cnt;
      if (ifc.clear) begin
        m_cnt = 0; m_ovf = 0;
      end else if (tk && m_gear == 1) begin
        if (m_cnt == 999) begin m_ovf = 1; m_cnt = SAT ? 999 : 0; end
        else m_cnt = m_cnt + 1;
      end else if (tk && m_gear == 2) begin
        if (m_cnt == 0) m_ovf = 1;
        else m_cnt = m_cnt - 1;
      end
      want = (ifc.drive == 2'b10) ? 1 : (ifc.drive == 2'b01) ? 2 : 0;
      if (m_gear == 0)         m_gear = want;
      else if (want != m_gear) m_gear = 0;
      h2 = h1; h1 = h0; h0 = ifc.wheel_pulse;
    end
  endtask

  // one clock: model follows the edge, outputs checked 1 time unit later
  task automatic clk_step();
    @(posedge clk_25MHz);
    model_edge();
    #1;
    chk("disp", int'({ifc.a, ifc.b, ifc.c}), to_bcd(m_disp));
    chk("ovf", int'(ifc.ovf), int'(m_ovf));
  endtask

  task automatic cyc(input int n);
    repeat (n) clk_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ifc.wheel_pulse = 1'b0; ifc.clear = 1'b0;
    ifc.frame_tick = 1'b0; ifc.drive = GEAR_P;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic pulse();
    ifc.wheel_pulse = 1'b1; cyc(2);
    ifc.wheel_pulse = 1'b0; cyc(2);
  endtask

  task automatic frame();
    ifc.frame_tick = 1'b1; cyc(1);
    ifc.frame_tick = 1'b0;
  endtask

  task automatic set_drive(input logic [1:0] d);
    ifc.drive = d; cyc(3);
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] drv;
    int         npulse;
    logic [11:0] exp_disp;
    bit         exp_ovf;
  } vec_t;

  vec_t tv [7];

  initial begin
    ifc.wheel_pulse = 1'b0; ifc.drive = GEAR_P;
    ifc.frame_tick = 1'b0; ifc.clear = 1'b0;

    tv[0] = '{1'b1, GEAR_D, 5,   12'h005, 1'b0};
    tv[1] = '{1'b0, GEAR_D, 94,  12'h099, 1'b0};
    tv[2] = '{1'b0, GEAR_D, 1,   12'h100, 1'b0};
    tv[3] = '{1'b1, GEAR_D, 1,   12'h001, 1'b0};
    tv[4] = '{1'b0, GEAR_R, 3,   12'h000, 1'b1};
    tv[5] = '{1'b1, GEAR_D, 999, 12'h999, 1'b0};
    tv[6] = '{1'b0, GEAR_D, 1,   SAT ? 12'h999 : 12'h000, 1'b1};

    do_reset();
    chk("reset_disp", int'({ifc.a, ifc.b, ifc.c}), 0);
    chk("reset_ovf", int'(ifc.ovf), 0);
    chk("reset_fsm", int'(dut.state_q), int'(ST_PARK));

    // scenario table
    for (int i = 0; i < 7; i++) begin
      if (tv[i].rst) do_reset();
      set_drive(tv[i].drv);
      for (int p = 0; p < tv[i].npulse; p++) pulse();
      cyc(4);
      frame();
      chk($sformatf("vec%0d_disp", i), int'({ifc.a, ifc.b, ifc.c}), int'(tv[i].exp_disp));
      chk($sformatf("vec%0d_ovf", i), int'(ifc.ovf), int'(tv[i].exp_ovf));
    end

    // tick and frame_tick on the same edge: display gets pre-update count
    do_reset(); set_drive(GEAR_D); pulse(); pulse(); frame();
    ifc.wheel_pulse = 1'b1; cyc(1);
    ifc.wheel_pulse = 1'b0; cyc(1);
    ifc.frame_tick = 1'b1; cyc(1); ifc.frame_tick = 1'b0;
    chk("tick_frame_pre", int'({ifc.a, ifc.b, ifc.c}), 12'h002);
    cyc(1); frame();
    chk("tick_frame_post", int'({ifc.a, ifc.b, ifc.c}), 12'h003);

    // D->R with the tick landing in the forced PARK cycle
    ifc.wheel_pulse = 1'b1; cyc(1);
    ifc.drive = GEAR_R; ifc.wheel_pulse = 1'b0; cyc(1);
    chk("forced_park", int'(dut.state_q), int'(ST_PARK));
    cyc(1);
    chk("rev_after_park", int'(dut.state_q), int'(ST_REV));
    cyc(3); frame();
    chk("park_tick_ignored", int'({ifc.a, ifc.b, ifc.c}), 12'h003);
    pulse(); cyc(2); frame();
    chk("rev_counts", int'({ifc.a, ifc.b, ifc.c}), 12'h002);

    // clear beats same-cycle tick; display holds 042 until next frame
    do_reset(); set_drive(GEAR_R); pulse();
    set_drive(GEAR_D);
    for (int p = 0; p < 42; p++) pulse();
    cyc(2); frame();
    chk("pre_clear_disp", int'({ifc.a, ifc.b, ifc.c}), 12'h042);
    chk("pre_clear_ovf", int'(ifc.ovf), 1);
    ifc.wheel_pulse = 1'b1; cyc(1);
    ifc.wheel_pulse = 1'b0; cyc(1);
    ifc.clear = 1'b1; cyc(1); ifc.clear = 1'b0;
    chk("clear_ovf", int'(ifc.ovf), 0);
    cyc(3);
    chk("clear_disp_held", int'({ifc.a, ifc.b, ifc.c}), 12'h042);
    frame();
    chk("clear_disp_new", int'({ifc.a, ifc.b, ifc.c}), 12'h000);

    // reset aborts a pulse already in the synchroniser
    do_reset(); set_drive(GEAR_D);
    ifc.wheel_pulse = 1'b1; cyc(1);
    rst_n = 1'b0; ifc.wheel_pulse = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(5); frame();
    chk("reset_abort", int'({ifc.a, ifc.b, ifc.c}), 12'h000);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) ifc.wheel_pulse = ~ifc.wheel_pulse;
      if ($urandom_range(0, 24) == 0) ifc.drive = 2'($urandom_range(0, 3));
      ifc.frame_tick = ($urandom_range(0, 7) == 0);
      ifc.clear      = ($urandom_range(0, 149) == 0);
      clk_step();
    end
    rst_n = 1'b1; ifc.clear = 1'b0; ifc.frame_tick = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/odo_bcd_counter.md
ODO_BCD_COUNTER -- requirements
Module: odo_bcd_counter

Interface
REQ-001 SHALL have port clk_25MHz  input  1  system pixel clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port wheel_pulse  input  1  raw wheel-encoder pulse, asynchronous to clk_25MHz.
REQ-004 SHALL have port drive  input  2  gear select: 2'b10 = D (forward), 2'b01 = R (reverse), 2'b00/2'b11 = P.
REQ-005 SHALL have port frame_tick  input  1  one-cycle strobe at start of vertical blank.
REQ-006 SHALL have port clear  input  1  synchronous trip reset, level-sampled each cycle.
REQ-007 SHALL have ports a, b, c  output  4 each  displayed hundreds, tens, units BCD digits.
REQ-008 SHALL have port ovf  output  1  sticky flag, count hit a limit.

Function
REQ-009 SHALL pass wheel_pulse through a 2-flop synchronizer plus one history flop; tick = sync2 & ~hist (rising edge only).
REQ-010 SHALL update the internal count on the 3rd rising clk edge at which wheel_pulse is sampled high; a pulse held high counts once.
REQ-011 SHALL run a gear FSM with states PARK, FWD, REV, registered from drive each cycle.
REQ-012 SHALL make FSM transitions: PARK->FWD on 2'b10, PARK->REV on 2'b01, FWD/REV->PARK on 2'b00/2'b11.
REQ-013 SHALL route a direct FWD<->REV request through PARK for exactly one cycle before entering the new state.
REQ-014 SHALL increment the 3-digit BCD count by one per tick in FWD and decrement by one per tick in REV.
REQ-015 SHALL ignore ticks in PARK, including the forced PARK cycle of REQ-013.
REQ-016 SHALL keep every digit in 0..9; units carry/borrow into tens, tens into hundreds, in one cycle.
REQ-017 SHALL floor the count at 000 in REV; a tick at 000 in REV leaves 000 and sets ovf.
REQ-018 SHALL give clear priority over a same-cycle tick: the count becomes 000 and ovf drops to 0.
REQ-019 SHALL copy the count to a/b/c only on cycles with frame_tick=1; a/b/c are otherwise held (tear-free display).
REQ-020 SHALL latch the pre-update count into a/b/c when tick and frame_tick occur in the same cycle.
REQ-021 SHALL hold a/b/c through a same-cycle clear and frame_tick; 000 appears at the next frame_tick.

Reset
REQ-022 SHALL, while rst_n=0 at a clock edge, set the count and a/b/c to 0, ovf to 0, FSM to PARK, and all sync/history flops to 0.
REQ-023 SHALL let reset abort any in-flight tick; no increment is applied after reset deasserts for a pulse sampled before it.

Configuration
REQ-024 SHALL, with ODO_SATURATE_EN defined, hold the count at 999 on a FWD tick and set ovf.
REQ-025 SHALL, without ODO_SATURATE_EN, wrap the count from 999 to 000 on a FWD tick and set ovf; the REV floor of REQ-017 applies in both builds.

Structure
REQ-026 SHALL place gear encodings (D/R/P), FSM state encodings, and the BCD max digit (9) in the shared odo_pkg package.
REQ-027 SHALL instantiate the sub-module bcd_digit three times: a mod-10 up/down digit with en, up, carry-in/borrow-in and carry/borrow-out.

Verification
REQ-028 SHALL cover: reset, then FWD with 5 pulses, then frame_tick -> a/b/c = 0/0/5, ovf = 0.
REQ-029 SHALL cover: count 0/9/9 in FWD, 1 pulse, then frame_tick -> a/b/c = 1/0/0.
REQ-030 SHALL cover: count 0/0/1 in REV, 3 pulses, then frame_tick -> a/b/c = 0/0/0, ovf = 1.
REQ-031 SHALL cover: count 9/9/9 in FWD, 1 pulse, then frame_tick -> 9/9/9 with ODO_SATURATE_EN and 0/0/0 without; ovf = 1 in both builds.
REQ-032 SHALL cover: drive switches 10->01 with a pulse edge landing in the forced PARK cycle -> count unchanged, FSM reaches REV one cycle later.
REQ-033 SHALL cover: clear and tick in the same cycle at count 0/4/2 -> count 000, ovf 0, a/b/c still 0/4/2 until the next frame_tick.
